// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multdiv sequencer.
package multdiv_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_TIMEOUT = 40;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } md_state_t;

endpackage

// File: rtl/multdiv_ctrl_hilo_regs.sv
// HI/LO architectural registers: MTxx write port, engine capture port, read mux.
module hilo_regs
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mt_we_hi,
    input  logic             mt_we_lo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             cap_we,
    input  logic [WIDTH-1:0] cap_hi,
    input  logic [WIDTH-1:0] cap_lo,
    input  logic             rd_sel_lo,
    output logic [WIDTH-1:0] rd_val
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Capture wins over MTxx; in practice they never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_we) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (mt_we_hi) hi <= mt_data;
            if (mt_we_lo) lo <= mt_data;
        end
    end

    assign rd_val = rd_sel_lo ? lo : hi;

endmodule

// File: rtl/multdiv_ctrl.sv
// MIPS mult/div sequencer: HI/LO hazard stall, engine start/capture, flush drain, watchdog.
// Optional MD_DIVZERO_BYPASS_EN: DIV/DIVU by zero completes in IDLE without the engine.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH,
    parameter int TIMEOUT = MD_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] rd_val,
    output logic             md_start,
    output logic             md_multdivb,
    output logic             md_signedop,
    output logic [WIDTH-1:0] md_x,
    output logic [WIDTH-1:0] md_y,
    input  logic [WIDTH-1:0] md_prodh,
    input  logic [WIDTH-1:0] md_prodl,
    input  logic             md_run,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    md_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    md_op_t        op;
    logic          accept;
    logic          capture;
    logic          divzero;
    logic          wd_fire;
    logic          mt_hi;
    logic          mt_lo;
    logic          cap_we;
    logic [WIDTH-1:0] cap_hi;
    logic [WIDTH-1:0] cap_lo;
    logic [CW-1:0] cnt_inc;

    assign op      = md_op_t'(issue_op);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        capture = 1'b0;
        divzero = 1'b0;
        wd_fire = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (issue_valid) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: accept = 1'b1;
                        OP_DIV, OP_DIVU: begin
`ifdef MD_DIVZERO_BYPASS_EN
                            if (rt_val == '0) divzero = 1'b1;
                            else              accept  = 1'b1;
`else
                            accept = 1'b1;
`endif
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
                if (accept) state_n = ST_START;
            end
            ST_START: begin
                cnt_n   = '0;
                state_n = flush ? ST_DRAIN : ST_BUSY;
            end
            ST_BUSY: begin
                // cnt==0 marks the first BUSY cycle, where md_run is not yet valid.
                if (cnt == CNT_MAX) begin
                    wd_fire = 1'b1;
                    state_n = ST_IDLE;
                end else if (flush) begin
                    cnt_n   = '0;
                    state_n = ST_DRAIN;
                end else if (cnt != '0 && !md_run) begin
                    capture = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_MAX) begin
                    wd_fire = 1'b1;
                    state_n = ST_IDLE;
                end else if (cnt != '0 && !md_run) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            md_x        <= '0;
            md_y        <= '0;
            md_multdivb <= 1'b0;
            md_signedop <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                md_x        <= rs_val;
                md_y        <= rt_val;
                md_multdivb <= ~issue_op[1];
                md_signedop <= ~issue_op[0];
            end
            if (wd_fire) timeout_err <= 1'b1;
        end
    end

    assign md_start = (state == ST_START) && !reset;
    assign stall    = issue_valid && (state != ST_IDLE);

    assign cap_we = capture | divzero;
    assign cap_hi = divzero ? rs_val : md_prodh;
    assign cap_lo = divzero ? {WIDTH{1'b1}} : md_prodl;

    hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk      (clk),
        .reset    (reset),
        .mt_we_hi (mt_hi),
        .mt_we_lo (mt_lo),
        .mt_data  (rs_val),
        .cap_we   (cap_we),
        .cap_hi   (cap_hi),
        .cap_lo   (cap_lo),
        .rd_sel_lo(issue_op[0]),
        .rd_val   (rd_val)
    );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl with a behavioural serial multdiv engine and a result scoreboard.
module tb_multdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] rd_val;
    logic        md_start;
    logic        md_multdivb;
    logic        md_signedop;
    logic [31:0] md_x;
    logic [31:0] md_y;
    logic [31:0] md_prodh = '0;
    logic [31:0] md_prodl = '0;
    logic        md_run = 1'b0;
    logic        timeout_err;

    int total = 0;
    int passed = 0;
    int starts = 0;
    int ecnt = 0;
    bit hang = 1'b0;
    logic [31:0] exp_q[$];

    multdiv_ctrl dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall), .rd_val(rd_val),
        .md_start(md_start), .md_multdivb(md_multdivb), .md_signedop(md_signedop),
        .md_x(md_x), .md_y(md_y), .md_prodh(md_prodh), .md_prodl(md_prodl),
        .md_run(md_run), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: 33 cycles for multiply, 34 for divide; x/0 gives hi=x, lo=all ones.
    function automatic logic [63:0] eng(input logic mul, input logic sgn,
                                        input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs, ys;
        logic [31:0] q, r;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        if (mul) return sgn ? 64'(xs * ys) : ({32'b0, x} * {32'b0, y});
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            q = 32'($signed(x) / $signed(y));
            r = 32'($signed(x) % $signed(y));
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (md_start) starts <= starts + 1;
        if (reset) begin
            md_run <= 1'b0;
            ecnt   <= 0;
        end else if (md_start) begin
            md_run <= 1'b1;
            ecnt   <= md_multdivb ? 33 : 34;
            {md_prodh, md_prodl} <= eng(md_multdivb, md_signedop, md_x, md_y);
        end else if (md_run && !hang) begin
            if (ecnt <= 1) md_run <= 1'b0;
            ecnt <= ecnt - 1;
        end
    end

    // Presents one op, holds it while stalled, returns rd_val and stall-cycle count.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rd, output int st);
        bit ok;
        ok = 1'b0;
        st = 0;
        rd = '0;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = op;
        rs_val = a;
        rt_val = b;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!stall) begin
                ok = 1'b1;
                rd = rd_val;
                break;
            end
            st++;
            @(negedge clk);
        end
        total++;
        if (!ok) $display("FAIL drive_stall_bound op=%0d stalled=%0d limit=200", op, st);
        else passed++;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        issue_valid = 1'b1;
        issue_op = 3'd6;
        #1;
        total += 8;
        if (stall !== 1'b0) $display("FAIL rst_stall got=%b want=0", stall); else passed++;
        if (rd_val !== 32'h0) $display("FAIL rst_hi got=%h want=0", rd_val); else passed++;
        if (md_start !== 1'b0) $display("FAIL rst_start got=%b want=0", md_start); else passed++;
        if (md_x !== 32'h0) $display("FAIL rst_x got=%h want=0", md_x); else passed++;
        if (md_y !== 32'h0) $display("FAIL rst_y got=%h want=0", md_y); else passed++;
        if (md_multdivb !== 1'b0) $display("FAIL rst_mdb got=%b want=0", md_multdivb); else passed++;
        if (md_signedop !== 1'b0) $display("FAIL rst_sgn got=%b want=0", md_signedop); else passed++;
        if (timeout_err !== 1'b0) $display("FAIL rst_to got=%b want=0", timeout_err); else passed++;
        issue_valid = 1'b0;
    endtask

    task automatic test_mult;
        logic [31:0] rd, e;
        int st, s0;
        s0 = starts;
        drive(3'd0, 32'h7FFF_FFFF, 32'h2, rd, st);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'hFFFF_FFFE);
        total += 4;
        if (md_start !== 1'b1) $display("FAIL mult_start got=%b want=1", md_start); else passed++;
        if (md_multdivb !== 1'b1) $display("FAIL mult_mdb got=%b want=1", md_multdivb); else passed++;
        if (md_signedop !== 1'b1) $display("FAIL mult_sgn got=%b want=1", md_signedop); else passed++;
        if (md_x !== 32'h7FFF_FFFF) $display("FAIL mult_x got=%h want=7fffffff", md_x); else passed++;
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== 35) $display("FAIL mult_latency got=%0d want=35", st); else passed++;
        if (rd !== e) $display("FAIL mult_hi got=%h want=%h", rd, e); else passed++;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (rd !== e) $display("FAIL mult_lo got=%h want=%h", rd, e); else passed++;
        if (starts !== s0 + 1) $display("FAIL mult_starts got=%0d want=%0d", starts, s0 + 1); else passed++;
    endtask

    task automatic test_div;
        logic [31:0] rd, e;
        int st;
        drive(3'd2, 32'hFFFF_FFF9, 32'h2, rd, st);
        exp_q.push_back(32'hFFFF_FFFD);
        exp_q.push_back(32'hFFFF_FFFF);
        total += 2;
        if (md_multdivb !== 1'b0) $display("FAIL div_mdb got=%b want=0", md_multdivb); else passed++;
        if (md_signedop !== 1'b1) $display("FAIL div_sgn got=%b want=1", md_signedop); else passed++;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== 36) $display("FAIL div_latency got=%0d want=36", st); else passed++;
        if (rd !== e) $display("FAIL div_lo got=%h want=%h", rd, e); else passed++;
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) $display("FAIL div_hi got=%h want=%h", rd, e); else passed++;
    endtask

    task automatic test_mtxx;
        logic [31:0] rd, e;
        int st;
        drive(3'd4, 32'h1234_5678, '0, rd, st);
        exp_q.push_back(32'h1234_5678);
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== 0) $display("FAIL mthi_stall got=%0d want=0", st); else passed++;
        if (rd !== e) $display("FAIL mthi_rd got=%h want=%h", rd, e); else passed++;
        flush = 1'b1;
        drive(3'd5, 32'hCAFE_F00D, '0, rd, st);
        exp_q.push_back(32'hCAFE_F00D);
        flush = 1'b0;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== 0) $display("FAIL mtlo_stall got=%0d want=0", st); else passed++;
        if (rd !== e) $display("FAIL mtlo_rd got=%h want=%h", rd, e); else passed++;
    endtask

    task automatic test_flush;
        logic [31:0] rd, e;
        int st, s0;
        drive(3'd4, 32'h1111_1111, '0, rd, st);
        drive(3'd5, 32'h2222_2222, '0, rd, st);
        exp_q.push_back(32'h1111_1111);
        exp_q.push_back(32'h2222_2222);
        s0 = starts;
        drive(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, st);
        repeat (6) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 3;
        if (st < 20) $display("FAIL flush_drain_stall got=%0d want>=20", st); else passed++;
        if (md_run !== 1'b0) $display("FAIL flush_run_at_release got=%b want=0", md_run); else passed++;
        if (rd !== e) $display("FAIL flush_hi got=%h want=%h", rd, e); else passed++;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (rd !== e) $display("FAIL flush_lo got=%h want=%h", rd, e); else passed++;
        if (starts !== s0 + 1) $display("FAIL flush_starts got=%0d want=%0d", starts, s0 + 1); else passed++;
    endtask

    task automatic test_divzero;
        logic [31:0] rd, e;
        int st, s0, want_st, want_s;
        s0 = starts;
`ifdef MD_DIVZERO_BYPASS_EN
        want_st = 0;
        want_s  = s0;
`else
        want_st = 36;
        want_s  = s0 + 1;
`endif
        drive(3'd3, 32'hABCD_EF01, 32'h0, rd, st);
        exp_q.push_back(32'hABCD_EF01);
        exp_q.push_back(32'hFFFF_FFFF);
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== want_st) $display("FAIL dz_stall got=%0d want=%0d", st, want_st); else passed++;
        if (rd !== e) $display("FAIL dz_hi got=%h want=%h", rd, e); else passed++;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (rd !== e) $display("FAIL dz_lo got=%h want=%h", rd, e); else passed++;
        if (starts !== want_s) $display("FAIL dz_starts got=%0d want=%0d", starts, want_s); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, e;
        int st;
        drive(3'd0, 32'd3, 32'd5, rd, st);
        drive(3'd3, 32'd100, 32'd7, rd, st);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd14);
        total++;
        if (st !== 35) $display("FAIL b2b_issue_stall got=%0d want=35", st); else passed++;
        drive(3'd6, '0, '0, rd, st);
        e = exp_q.pop_front();
        total += 2;
        if (st !== 36) $display("FAIL b2b_latency got=%0d want=36", st); else passed++;
        if (rd !== e) $display("FAIL b2b_hi got=%h want=%h", rd, e); else passed++;
        drive(3'd7, '0, '0, rd, st);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) $display("FAIL b2b_lo got=%h want=%h", rd, e); else passed++;
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        int st;
        hang = 1'b1;
        drive(3'd0, 32'd2, 32'd3, rd, st);
        repeat (41) @(posedge clk);
        #1;
        total++;
        if (timeout_err !== 1'b0) $display("FAIL to_early got=%b want=0", timeout_err); else passed++;
        @(posedge clk);
        #1;
        issue_valid = 1'b1;
        issue_op = 3'd6;
        #1;
        total += 3;
        if (timeout_err !== 1'b1) $display("FAIL to_set got=%b want=1", timeout_err); else passed++;
        if (stall !== 1'b0) $display("FAIL to_idle_stall got=%b want=0", stall); else passed++;
        if (rd_val !== 32'd2) $display("FAIL to_hi_kept got=%h want=2", rd_val); else passed++;
        issue_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue_valid = 1'b1;
        issue_op = 3'd7;
        #1;
        total += 6;
        if (timeout_err !== 1'b0) $display("FAIL to_clr got=%b want=0", timeout_err); else passed++;
        if (md_x !== 32'h0) $display("FAIL to_rst_x got=%h want=0", md_x); else passed++;
        if (md_y !== 32'h0) $display("FAIL to_rst_y got=%h want=0", md_y); else passed++;
        if (md_multdivb !== 1'b0) $display("FAIL to_rst_mdb got=%b want=0", md_multdivb); else passed++;
        if (md_signedop !== 1'b0) $display("FAIL to_rst_sgn got=%b want=0", md_signedop); else passed++;
        if (rd_val !== 32'h0) $display("FAIL to_rst_lo got=%h want=0", rd_val); else passed++;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd;
        int st, s0;
        s0 = starts;
        drive(3'd0, 32'd9, 32'd9, rd, st);
        reset = 1'b1;
        #1;
        total++;
        if (md_start !== 1'b0) $display("FAIL midrst_start got=%b want=0", md_start); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue_valid = 1'b1;
        issue_op = 3'd6;
        #1;
        total += 3;
        if (stall !== 1'b0) $display("FAIL midrst_stall got=%b want=0", stall); else passed++;
        if (starts !== s0) $display("FAIL midrst_starts got=%0d want=%0d", starts, s0); else passed++;
        if (rd_val !== 32'h0) $display("FAIL midrst_hi got=%h want=0", rd_val); else passed++;
        issue_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtxx();
        test_flush();
        test_divzero();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
